// File: rtl/seq_pkg.sv
// Shared definitions for the serial w/z pattern source: FSM state type and a
// constant-evaluable ceiling log2 used to size the length and match counters.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: sends a captured pattern LSB-first on w and counts
// adjacent 1-1 pairs in the emitted stream. Optional frame repeat: SERIAL_PATTERN_GEN_REPEAT_EN.
module serial_pattern_gen
  import seq_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic             w,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
  // "repeat" is a reserved word, so the repeat request is named repeat_i
  , input logic            repeat_i
`endif
);

  state_e           state_q;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] left_q;
  logic [CNT_W-1:0] last_q;
  logic             prev_q;
  logic             w_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] match_q;

  logic [CNT_W-1:0] last_d;
  logic             rep;
  logic             reload;
  logic             nxt_bit;
  logic [WIDTH-1:0] nxt_shreg;
  logic [CNT_W-1:0] match_d;

`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
  assign rep = repeat_i;
`else
  assign rep = 1'b0;
`endif

  // last_d is the index of the final bit (effective length minus one)
  always_comb begin
    last_d = CNT_W'(WIDTH - 1);
    if (len != '0 && len <= CNT_W'(WIDTH)) last_d = len - CNT_W'(1);
  end

  // Repeat restarts from the captured pattern, so bit 0 comes from pat_q, not the shifter
  always_comb begin
    reload    = (left_q == '0);
    nxt_bit   = reload ? pat_q[0] : shreg_q[0];
    nxt_shreg = reload ? (pat_q >> 1) : (shreg_q >> 1);
    match_d   = match_q;
    if (prev_q && nxt_bit && (match_q != '1)) match_d = match_q + CNT_W'(1);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      pat_q   <= '0;
      shreg_q <= '0;
      left_q  <= '0;
      last_q  <= '0;
      prev_q  <= 1'b0;
      w_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= SHIFT;
            pat_q   <= pattern;
            shreg_q <= pattern >> 1;
            left_q  <= last_d;
            last_q  <= last_d;
            w_q     <= pattern[0];
            prev_q  <= pattern[0];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            match_q <= '0;
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q <= IDLE;
            w_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (!reload || rep) begin
            w_q     <= nxt_bit;
            prev_q  <= nxt_bit;
            shreg_q <= nxt_shreg;
            left_q  <= reload ? last_q : left_q - CNT_W'(1);
            match_q <= match_d;
          end else begin
            state_q <= DONE;
            w_q     <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          w_q     <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          w_q     <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign w         = w_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign match_cnt = match_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Scoreboard bench for serial_pattern_gen: stimulus pushes expected (cycle, bit) and
// (cycle, match count) records; a negedge monitor pops and compares them.
module tb_serial_pattern_gen;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             Clock;
  logic             Resetn;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] len;
  logic             abort;
  logic             w;
  logic             valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;
  logic             rep;

  serial_pattern_gen #(.WIDTH(WIDTH)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .abort     (abort),
    .w         (w),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .match_cnt (match_cnt)
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
    , .repeat_i (rep)
`endif
  );

  typedef struct {
    int unsigned cyc;
    int unsigned val;
  } exp_t;

  exp_t        exp_bits[$];
  exp_t        exp_done[$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_pass;
  bit          mon_en;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Monitor: every valid bit and every done pulse must match the head of its queue
  always @(negedge Clock) begin
    if (mon_en && Resetn) begin
      exp_t e;
      while (exp_bits.size() > 0 && exp_bits[0].cyc < cyc) begin
        e = exp_bits.pop_front();
        n_checks++;
        $display("FAIL missing_bit: got none expected bit at cycle %0d", e.cyc);
      end
      while (exp_done.size() > 0 && exp_done[0].cyc < cyc) begin
        e = exp_done.pop_front();
        n_checks++;
        $display("FAIL missing_done: got none expected done at cycle %0d", e.cyc);
      end
      if (valid) begin
        if (exp_bits.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_bit: got w=%0d expected no valid (cycle %0d)", w, cyc);
        end else begin
          e = exp_bits.pop_front();
          chk("bit_cycle", cyc, e.cyc);
          chk("bit_value", 32'(w), e.val);
        end
      end else begin
        chk("w_idle_zero", 32'(w), 0);
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
        end else begin
          e = exp_done.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_match_cnt", 32'(match_cnt), e.val);
        end
        chk("done_valid_low", 32'(valid), 0);
      end
    end
  end

  function automatic int unsigned eff_len(input int unsigned l);
    return (l == 0 || l > WIDTH) ? WIDTH : l;
  endfunction

  // Caller is at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_frame(input logic [WIDTH-1:0] p, input int unsigned ln,
                           input int abort_at, input bit poke, input bit abort_with_start);
    int unsigned L, c, nb, m;
    exp_t e;
    L  = eff_len(ln);
    c  = cyc;
    nb = (abort_at >= 0) ? unsigned'(abort_at) + 1 : L;
    m  = 0;
    for (int unsigned i = 0; i < nb; i++) begin
      e.cyc = c + 1 + i;
      e.val = 32'(p[i]);
      exp_bits.push_back(e);
      if (i > 0 && p[i] && p[i-1]) m++;
    end
    if (abort_at < 0) begin
      e.cyc = c + 1 + L;
      e.val = m;
      exp_done.push_back(e);
    end
    pattern = p;
    len     = CNT_W'(ln);
    start   = 1'b1;
    abort   = abort_with_start;
    @(negedge Clock);
    pattern = WIDTH'($urandom);
    len     = CNT_W'($urandom);
    for (int j = 0; j <= int'(L); j++) begin
      abort = (j == abort_at);
      start = (poke && j == 2);
      if (poke && j == 2) pattern = ~p;
      if (j == 0) chk("busy_first_bit", 32'(busy), 1);
      if (j == int'(L)) chk("busy_in_done", 32'(busy), 1);
      @(negedge Clock);
      if (j == abort_at) begin
        abort = 1'b0;
        start = 1'b0;
        chk("abort_valid", 32'(valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_match_hold", 32'(match_cnt), m);
        return;
      end
    end
    abort = 1'b0;
    start = 1'b0;
    chk("busy_after_done", 32'(busy), 0);
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_pass   = 0;
    mon_en   = 1'b0;
    Resetn   = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    rep      = 1'b0;
    pattern  = '0;
    len      = '0;
    #2;
    chk("reset_outputs", {27'd0, w, valid, busy, done}, 0);
    chk("reset_match", 32'(match_cnt), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    mon_en = 1'b1;
    @(negedge Clock);

    run_frame(8'b0110_1101, 8, -1, 1'b0, 1'b0);
    run_frame(8'hFF, 0, -1, 1'b0, 1'b0);
    run_frame(8'hFF, 3, -1, 1'b0, 1'b0);
    run_frame(8'hB7, 8, -1, 1'b1, 1'b0);
    run_frame(8'hFF, 8, 2, 1'b0, 1'b0);
    run_frame(8'h5E, 12, -1, 1'b0, 1'b1);
    run_frame(8'h01, 1, -1, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int unsigned ln;
      int          ab;
      ln = $urandom_range(0, 15);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, eff_len(ln) - 1)) : -1;
      run_frame(WIDTH'($urandom), ln, ab, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      repeat ($urandom_range(0, 2)) @(negedge Clock);
    end

    // Asynchronous reset in the middle of a frame
    mon_en  = 1'b0;
    pattern = 8'hFF;
    len     = 4'd8;
    start   = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    repeat (3) @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    chk("midframe_reset_outputs", {27'd0, w, valid, busy, done}, 0);
    chk("midframe_reset_match", 32'(match_cnt), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    exp_bits.delete();
    exp_done.delete();
    mon_en = 1'b1;
    @(negedge Clock);

`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
    begin
      int unsigned c;
      exp_t e;
      c = cyc;
      for (int unsigned i = 0; i < 6; i++) begin
        e.cyc = c + 1 + i;
        e.val = 1;
        exp_bits.push_back(e);
      end
      e.cyc = c + 7;
      e.val = 5;
      exp_done.push_back(e);
      pattern = 8'h03;
      len     = 4'd2;
      start   = 1'b1;
      rep     = 1'b1;
      @(negedge Clock);
      start = 1'b0;
      repeat (5) @(negedge Clock);
      rep = 1'b0;
      repeat (3) @(negedge Clock);
    end
`endif

    repeat (3) @(negedge Clock);
    chk("leftover_bits", exp_bits.size(), 0);
    chk("leftover_done", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
